// File: rtl/enqueue_buffer_writer_pkg.sv
// rtl/enqueue_buffer_writer_pkg.sv - shared types and constants for the enqueue buffer writer
package enqueue_buffer_writer_pkg;

   localparam int DATA_WIDTH_DEF      = 256;
   localparam int KEEP_WIDTH_DEF      = 32;
   localparam int PKT_INFO_WIDTH      = DATA_WIDTH_DEF + KEEP_WIDTH_DEF + 1;
   localparam int PKT_ADDR_WIDTH_DEF  = 12;
   localparam int META_ADDR_WIDTH_DEF = 11;
   localparam int PORT_COUNT_DEF      = 5;
   localparam int PORT_CNT_WIDTH      = 11;

   localparam int DESC_META_W  = META_ADDR_WIDTH_DEF;
   localparam int DESC_PKT_W   = PKT_ADDR_WIDTH_DEF;
   localparam int DESC_LEN_W   = PKT_ADDR_WIDTH_DEF + 1;
   localparam int DESC_PORTS_W = PORT_COUNT_DEF;

   localparam int ERR_PROTOCOL      = 0;
   localparam int ERR_OVERFLOW      = 1;
   localparam int ERR_REL_UNDERFLOW = 2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BODY = 1'b1
   } enq_state_t;

   // Field order fixes the packed offsets: err at bit 0, meta_addr at the top.
   typedef struct packed {
      logic [DESC_META_W-1:0]  meta_addr;
      logic [DESC_PKT_W-1:0]   pkt_addr;
      logic [DESC_LEN_W-1:0]   len;
      logic [DESC_PORTS_W-1:0] ports;
      logic                    err;
   } desc_t;

endpackage

// File: rtl/enq_port_counter.sv
// rtl/enq_port_counter.sv - saturating per-port queued-packet counter with threshold compare
module enq_port_counter
   import enqueue_buffer_writer_pkg::*;
#(
   parameter int W      = PORT_CNT_WIDTH,
   parameter int THRESH = 200
) (
   input  logic clk,
   input  logic rst,
   input  logic i_inc,
   input  logic i_dec,
   output logic o_at_thresh
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else begin
         case ({i_inc, i_dec})
            2'b10:   if (r_count != {W{1'b1}}) r_count <= r_count + 1'b1;
            2'b01:   if (r_count != '0) r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_at_thresh = (r_count >= W'(THRESH));

endmodule

// File: rtl/enqueue_buffer_writer.sv
// rtl/enqueue_buffer_writer.sv - registered packet/metadata write ports, descriptors, free-space and port tracking
// Optional ENQ_BUF_STATS_EN adds m_axis_stat_pkts / m_axis_stat_drops counters.
module enqueue_buffer_writer
   import enqueue_buffer_writer_pkg::*;
#(
   parameter int DATA_WIDTH        = DATA_WIDTH_DEF,
   parameter int KEEP_WIDTH        = KEEP_WIDTH_DEF,
   parameter int SUME_WIDTH        = 128,
   parameter int OUTPUT_PORT_COUNT = PORT_COUNT_DEF,
   parameter int PKT_ADDR_WIDTH    = PKT_ADDR_WIDTH_DEF,
   parameter int META_ADDR_WIDTH   = META_ADDR_WIDTH_DEF,
   parameter int MAX_PKT_BEATS     = 64,
   parameter int PORT_PKT_THRESH   = 200
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [DATA_WIDTH+KEEP_WIDTH:0]       s_axis_pkt_info,
   input  logic [SUME_WIDTH-1:0]                s_axis_sume_meta,
   input  logic [OUTPUT_PORT_COUNT-1:0]         s_axis_output_port_bit_array,
   input  logic                                 s_axis_ctl_pkt_wr_en,
   input  logic                                 s_axis_ctl_pkt_addr_update,
   input  logic                                 s_axis_ctl_meta_wr_en,
   input  logic                                 s_axis_ctl_meta_addr_update,
   input  logic                                 s_axis_release_valid,
   input  logic [PKT_ADDR_WIDTH:0]              s_axis_release_beats,
   input  logic [OUTPUT_PORT_COUNT-1:0]         s_axis_port_deq,
   output logic                                 m_axis_pkt_mem_we,
   output logic [PKT_ADDR_WIDTH-1:0]            m_axis_pkt_mem_addr,
   output logic [DATA_WIDTH+KEEP_WIDTH:0]       m_axis_pkt_mem_din,
   output logic                                 m_axis_meta_mem_we,
   output logic [META_ADDR_WIDTH-1:0]           m_axis_meta_mem_addr,
   output logic [SUME_WIDTH-1:0]                m_axis_meta_mem_din,
   output logic                                 m_axis_desc_valid,
   output logic [META_ADDR_WIDTH-1:0]           m_axis_desc_meta_addr,
   output logic [PKT_ADDR_WIDTH-1:0]            m_axis_desc_pkt_addr,
   output logic [PKT_ADDR_WIDTH:0]              m_axis_desc_len,
   output logic [OUTPUT_PORT_COUNT-1:0]         m_axis_desc_ports,
   output logic                                 m_axis_desc_err,
   output logic [OUTPUT_PORT_COUNT-1:0]         m_axis_buffer_almost_full_bit_array,
   output logic [2:0]                           m_axis_err_flags
`ifdef ENQ_BUF_STATS_EN
   ,
   output logic [31:0]                          m_axis_stat_pkts,
   output logic [31:0]                          m_axis_stat_drops
`endif
);

   localparam logic [PKT_ADDR_WIDTH:0] DEPTH = {1'b1, {PKT_ADDR_WIDTH{1'b0}}};

   enq_state_t                     r_state;
   logic [PKT_ADDR_WIDTH-1:0]      r_pkt_ptr;
   logic [META_ADDR_WIDTH-1:0]     r_meta_ptr;
   logic [PKT_ADDR_WIDTH:0]        r_free;
   desc_t                          r_cur;
   desc_t                          r_desc;
   logic                           r_desc_valid;
   logic                           r_pkt_we;
   logic [PKT_ADDR_WIDTH-1:0]      r_pkt_addr;
   logic [DATA_WIDTH+KEEP_WIDTH:0] r_pkt_din;
   logic                           r_meta_we;
   logic [META_ADDR_WIDTH-1:0]     r_meta_addr;
   logic [SUME_WIDTH-1:0]          r_meta_din;
   logic [2:0]                     r_err_flags;
   logic [OUTPUT_PORT_COUNT-1:0]   r_af;

   logic                           w_start, w_drop, w_accept, w_full, w_write, w_emit;
   logic                           w_pkt_adv, w_meta_adv;
   logic [PKT_ADDR_WIDTH:0]        w_rel;
   logic [PKT_ADDR_WIDTH+1:0]      w_free_sum;
   logic                           w_rel_over;
   logic [2:0]                     w_err_set;
   desc_t                          w_desc;
   logic [OUTPUT_PORT_COUNT-1:0]   w_inc, w_ge;

   assign w_start    = (r_state == ST_IDLE) & s_axis_ctl_meta_wr_en & s_axis_ctl_pkt_wr_en;
   assign w_drop     = (r_state == ST_IDLE) & s_axis_ctl_pkt_wr_en & ~s_axis_ctl_meta_wr_en;
   assign w_accept   = w_start | ((r_state == ST_BODY) & s_axis_ctl_pkt_wr_en);
   assign w_full     = (r_free == '0);
   assign w_write    = w_accept & ~w_full;
   assign w_emit     = w_accept & s_axis_pkt_info[0];
   // A strobed beat that was not written must not consume an address.
   assign w_pkt_adv  = s_axis_ctl_pkt_addr_update & ~(s_axis_ctl_pkt_wr_en & ~w_write);
   assign w_meta_adv = s_axis_ctl_meta_addr_update & ~(s_axis_ctl_meta_wr_en & ~w_start);

   assign w_rel      = s_axis_release_valid ? s_axis_release_beats : '0;
   assign w_free_sum = {1'b0, r_free} + {1'b0, w_rel} - {{(PKT_ADDR_WIDTH+1){1'b0}}, w_write};
   assign w_rel_over = (w_free_sum > {1'b0, DEPTH});

   always_comb begin
      w_desc.meta_addr = w_start ? r_meta_ptr : r_cur.meta_addr;
      w_desc.pkt_addr  = w_start ? r_pkt_ptr : r_cur.pkt_addr;
      w_desc.len       = w_start ? {{PKT_ADDR_WIDTH{1'b0}}, 1'b1} : r_cur.len + 1'b1;
      w_desc.ports     = w_start ? s_axis_output_port_bit_array : r_cur.ports;
      w_desc.err       = (w_start ? 1'b0 : r_cur.err) | w_full;
      w_err_set                    = '0;
      w_err_set[ERR_PROTOCOL]      = w_drop | ((r_state == ST_BODY) & s_axis_ctl_meta_wr_en);
      w_err_set[ERR_OVERFLOW]      = w_accept & w_full;
      w_err_set[ERR_REL_UNDERFLOW] = w_rel_over;
   end

   assign w_inc = (w_emit & ~w_desc.err) ? w_desc.ports : '0;

   for (genvar p = 0; p < OUTPUT_PORT_COUNT; p++) begin : g_port
      enq_port_counter #(.W(PORT_CNT_WIDTH), .THRESH(PORT_PKT_THRESH)) u_cnt (
         .clk         (clk),
         .rst         (rst),
         .i_inc       (w_inc[p]),
         .i_dec       (s_axis_port_deq[p]),
         .o_at_thresh (w_ge[p])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_pkt_ptr    <= '0;
         r_meta_ptr   <= '0;
         r_free       <= DEPTH;
         r_cur        <= '0;
         r_desc       <= '0;
         r_desc_valid <= 1'b0;
         r_pkt_we     <= 1'b0;
         r_pkt_addr   <= '0;
         r_pkt_din    <= '0;
         r_meta_we    <= 1'b0;
         r_meta_addr  <= '0;
         r_meta_din   <= '0;
         r_err_flags  <= '0;
         r_af         <= '0;
      end else begin
         r_pkt_we <= w_write;
         if (w_write) begin
            r_pkt_addr <= r_pkt_ptr;
            r_pkt_din  <= s_axis_pkt_info;
         end
         r_meta_we <= w_start;
         if (w_start) begin
            r_meta_addr <= r_meta_ptr;
            r_meta_din  <= s_axis_sume_meta;
         end
         if (w_pkt_adv)  r_pkt_ptr  <= r_pkt_ptr + 1'b1;
         if (w_meta_adv) r_meta_ptr <= r_meta_ptr + 1'b1;
         if (w_accept)   r_cur      <= w_desc;
         r_desc_valid <= w_emit;
         if (w_emit)     r_desc     <= w_desc;
         r_free      <= w_rel_over ? DEPTH : w_free_sum[PKT_ADDR_WIDTH:0];
         r_err_flags <= r_err_flags | w_err_set;
         r_af        <= w_ge | {OUTPUT_PORT_COUNT{r_free < (PKT_ADDR_WIDTH+1)'(MAX_PKT_BEATS)}};
         if (w_start && !s_axis_pkt_info[0])
            r_state <= ST_BODY;
         else if (w_emit)
            r_state <= ST_IDLE;
      end
   end

`ifdef ENQ_BUF_STATS_EN
   logic [31:0] r_stat_pkts, r_stat_drops;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stat_pkts  <= '0;
         r_stat_drops <= '0;
      end else begin
         if (w_emit && !w_desc.err) r_stat_pkts <= r_stat_pkts + 1'b1;
         if ((w_emit && w_desc.err) || w_drop) r_stat_drops <= r_stat_drops + 1'b1;
      end
   end

   assign m_axis_stat_pkts  = r_stat_pkts;
   assign m_axis_stat_drops = r_stat_drops;
`endif

   assign m_axis_pkt_mem_we                   = r_pkt_we;
   assign m_axis_pkt_mem_addr                 = r_pkt_addr;
   assign m_axis_pkt_mem_din                  = r_pkt_din;
   assign m_axis_meta_mem_we                  = r_meta_we;
   assign m_axis_meta_mem_addr                = r_meta_addr;
   assign m_axis_meta_mem_din                 = r_meta_din;
   assign m_axis_desc_valid                   = r_desc_valid;
   assign m_axis_desc_meta_addr               = r_desc.meta_addr;
   assign m_axis_desc_pkt_addr                = r_desc.pkt_addr;
   assign m_axis_desc_len                     = r_desc.len;
   assign m_axis_desc_ports                   = r_desc.ports;
   assign m_axis_desc_err                     = r_desc.err;
   assign m_axis_buffer_almost_full_bit_array = r_af;
   assign m_axis_err_flags                    = r_err_flags;

endmodule

// File: tb/tb_enqueue_buffer_writer.sv
// tb/tb_enqueue_buffer_writer.sv - directed self-checking bench for enqueue_buffer_writer
module tb_enqueue_buffer_writer;

   localparam int DW  = 256;
   localparam int KW  = 32;
   localparam int SW  = 128;
   localparam int NP  = 5;
   localparam int PAW = 12;
   localparam int MAW = 11;
   localparam int PIW = DW + KW + 1;

   logic           clk = 1'b0;
   logic           rst;
   logic [PIW-1:0] pkt_info;
   logic [SW-1:0]  sume;
   logic [NP-1:0]  ports_in;
   logic           pkt_wr, pkt_upd, meta_wr, meta_upd;
   logic           rel_valid;
   logic [PAW:0]   rel_beats;
   logic [NP-1:0]  port_deq;
   logic           pkt_we;
   logic [PAW-1:0] pkt_addr;
   logic [PIW-1:0] pkt_din;
   logic           meta_we;
   logic [MAW-1:0] meta_addr;
   logic [SW-1:0]  meta_din;
   logic           desc_valid;
   logic [MAW-1:0] desc_meta_addr;
   logic [PAW-1:0] desc_pkt_addr;
   logic [PAW:0]   desc_len;
   logic [NP-1:0]  desc_ports;
   logic           desc_err;
   logic [NP-1:0]  af;
   logic [2:0]     flags;
`ifdef ENQ_BUF_STATS_EN
   logic [31:0]    stat_pkts, stat_drops;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   enqueue_buffer_writer dut (
      .clk                                 (clk),
      .rst                                 (rst),
      .s_axis_pkt_info                     (pkt_info),
      .s_axis_sume_meta                    (sume),
      .s_axis_output_port_bit_array        (ports_in),
      .s_axis_ctl_pkt_wr_en                (pkt_wr),
      .s_axis_ctl_pkt_addr_update          (pkt_upd),
      .s_axis_ctl_meta_wr_en               (meta_wr),
      .s_axis_ctl_meta_addr_update         (meta_upd),
      .s_axis_release_valid                (rel_valid),
      .s_axis_release_beats                (rel_beats),
      .s_axis_port_deq                     (port_deq),
      .m_axis_pkt_mem_we                   (pkt_we),
      .m_axis_pkt_mem_addr                 (pkt_addr),
      .m_axis_pkt_mem_din                  (pkt_din),
      .m_axis_meta_mem_we                  (meta_we),
      .m_axis_meta_mem_addr                (meta_addr),
      .m_axis_meta_mem_din                 (meta_din),
      .m_axis_desc_valid                   (desc_valid),
      .m_axis_desc_meta_addr               (desc_meta_addr),
      .m_axis_desc_pkt_addr                (desc_pkt_addr),
      .m_axis_desc_len                     (desc_len),
      .m_axis_desc_ports                   (desc_ports),
      .m_axis_desc_err                     (desc_err),
      .m_axis_buffer_almost_full_bit_array (af),
      .m_axis_err_flags                    (flags)
`ifdef ENQ_BUF_STATS_EN
      ,
      .m_axis_stat_pkts                    (stat_pkts),
      .m_axis_stat_drops                   (stat_drops)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic clear_inputs();
      pkt_info  = '0;
      sume      = '0;
      ports_in  = '0;
      pkt_wr    = 1'b0;
      pkt_upd   = 1'b0;
      meta_wr   = 1'b0;
      meta_upd  = 1'b0;
      rel_valid = 1'b0;
      rel_beats = '0;
      port_deq  = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      idle(2);
      rst = 1'b0;
   endtask

   // Release/deq strobes set by the caller ride along with this beat only.
   task automatic beat(input logic first, input logic last, input logic [31:0] d, input logic [NP-1:0] ports);
      pkt_info = {{(DW-32){1'b0}}, d, {KW{1'b1}}, last};
      sume     = {{(SW-32){1'b0}}, ~d};
      ports_in = ports;
      pkt_wr   = 1'b1;
      pkt_upd  = 1'b1;
      meta_wr  = first;
      meta_upd = first;
      tick();
      pkt_wr    = 1'b0;
      pkt_upd   = 1'b0;
      meta_wr   = 1'b0;
      meta_upd  = 1'b0;
      rel_valid = 1'b0;
      rel_beats = '0;
      port_deq  = '0;
   endtask

   task automatic pkt(input int n, input logic [NP-1:0] ports);
      for (int i = 0; i < n; i++) beat(i == 0, i == n - 1, 32'(i), ports);
   endtask

   task automatic release_n(input int n);
      rel_valid = 1'b1;
      rel_beats = (PAW+1)'(n);
      tick();
      rel_valid = 1'b0;
      rel_beats = '0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      do_reset();
      chk("rst_pkt_we", pkt_we, 0);
      chk("rst_pkt_addr", pkt_addr, 0);
      chk("rst_desc_valid", desc_valid, 0);
      chk("rst_af", af, 0);
      chk("rst_flags", flags, 0);

      // 3-beat packet to port 2
      beat(1'b1, 1'b0, 32'hA0, 5'b00100);
      chk("p3_b0_we", pkt_we, 1);
      chk("p3_b0_addr", pkt_addr, 0);
      chk("p3_b0_meta_we", meta_we, 1);
      chk("p3_b0_meta_addr", meta_addr, 0);
      chk("p3_b0_data", pkt_din[KW+1 +: 32], 64'hA0);
      chk("p3_b0_meta_din", meta_din[31:0], 64'hFFFFFF5F);
      beat(1'b0, 1'b0, 32'hA1, 5'b00100);
      chk("p3_b1_addr", pkt_addr, 1);
      chk("p3_b1_meta_we", meta_we, 0);
      chk("p3_b1_desc_valid", desc_valid, 0);
      beat(1'b0, 1'b1, 32'hA2, 5'b00100);
      chk("p3_b2_we", pkt_we, 1);
      chk("p3_b2_addr", pkt_addr, 2);
      chk("p3_desc_valid", desc_valid, 1);
      chk("p3_desc_pkt_addr", desc_pkt_addr, 0);
      chk("p3_desc_meta_addr", desc_meta_addr, 0);
      chk("p3_desc_len", desc_len, 3);
      chk("p3_desc_ports", desc_ports, 5'b00100);
      chk("p3_desc_err", desc_err, 0);
      idle(1);
      chk("p3_desc_one_cycle", desc_valid, 0);

      // single-beat packets back to back, then an orphan beat
      do_reset();
      beat(1'b1, 1'b1, 32'hB0, 5'b00010);
      chk("p1_desc_valid", desc_valid, 1);
      chk("p1_desc_len", desc_len, 1);
      chk("p1_desc_pkt_addr", desc_pkt_addr, 0);
      beat(1'b1, 1'b1, 32'hB1, 5'b00010);
      chk("p1b_desc_valid", desc_valid, 1);
      chk("p1b_pkt_addr", pkt_addr, 1);
      chk("p1b_desc_pkt_addr", desc_pkt_addr, 1);
      chk("p1b_desc_meta_addr", desc_meta_addr, 1);
      chk("p1b_flags", flags, 0);
      beat(1'b0, 1'b0, 32'hB2, 5'b00010);
      chk("orphan_we", pkt_we, 0);
      chk("orphan_flags", flags, 3'b001);

      // pointer wrap
      do_reset();
      pkt(4094, 5'b00000);
      release_n(4094);
      for (int i = 0; i < 4; i++) begin
         beat(i == 0, i == 3, 32'hC0 + 32'(i), 5'b01000);
         chk("wrap_addr", pkt_addr, (4094 + i) % 4096);
      end
      chk("wrap_desc_pkt_addr", desc_pkt_addr, 4094);
      chk("wrap_desc_len", desc_len, 4);
      chk("wrap_flags", flags, 0);

      // overflow: 4097 beats with no release
      do_reset();
      for (int i = 0; i <= 4096; i++) begin
         beat(i == 0, i == 4096, 32'(i), 5'b00001);
         if (i == 4095) begin
            chk("ovf_last_ok_we", pkt_we, 1);
            chk("ovf_last_ok_addr", pkt_addr, 4095);
         end
      end
      chk("ovf_we_suppressed", pkt_we, 0);
      chk("ovf_desc_valid", desc_valid, 1);
      chk("ovf_desc_err", desc_err, 1);
      chk("ovf_desc_len", desc_len, 4097);
      chk("ovf_flags", flags, 3'b010);
      idle(1);
      chk("ovf_af", af, 5'b11111);

      // per-port count threshold, simultaneous inc/dec
      do_reset();
      for (int i = 0; i < 199; i++) pkt(1, 5'b00001);
      idle(2);
      chk("cnt199_af", af, 5'b00000);
      pkt(1, 5'b00001);
      idle(2);
      chk("cnt200_af", af, 5'b00001);
      port_deq = 5'b00001;
      pkt(1, 5'b00001);
      idle(2);
      chk("cnt_incdec_af", af, 5'b00001);
      port_deq = 5'b00001;
      tick();
      port_deq = 5'b00000;
      idle(2);
      chk("cnt_deq_af", af, 5'b00000);

      // free-space accounting with simultaneous release and write
      do_reset();
      pkt(3996, 5'b00000);
      idle(2);
      chk("free100_af", af, 5'b00000);
      rel_valid = 1'b1;
      rel_beats = 13'd10;
      pkt(1, 5'b00000);
      pkt(45, 5'b00000);
      idle(2);
      chk("free64_af", af, 5'b00000);
      pkt(1, 5'b00000);
      idle(2);
      chk("free63_af", af, 5'b11111);
      release_n(4033);
      idle(2);
      chk("free_full_af", af, 5'b00000);
      chk("free_full_flags", flags, 3'b000);
      release_n(1);
      chk("rel_underflow_flags", flags, 3'b100);

      // reset in the middle of a packet
      do_reset();
      beat(1'b1, 1'b0, 32'hD0, 5'b01000);
      beat(1'b0, 1'b0, 32'hD1, 5'b01000);
      rst = 1'b1;
      #1;
      chk("mid_rst_we", pkt_we, 0);
      chk("mid_rst_addr", pkt_addr, 0);
      chk("mid_rst_meta_addr", meta_addr, 0);
      chk("mid_rst_desc_valid", desc_valid, 0);
      tick();
      rst = 1'b0;
      release_n(1);
      chk("mid_rst_free_depth", flags, 3'b100);
      beat(1'b1, 1'b1, 32'hD2, 5'b01000);
      chk("mid_rst_next_addr", pkt_addr, 0);
      chk("mid_rst_next_desc_addr", desc_pkt_addr, 0);
      chk("mid_rst_next_desc_meta", desc_meta_addr, 0);
      chk("mid_rst_next_len", desc_len, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/enqueue_buffer_writer.md
# enqueue_buffer_writer

Sits directly downstream of the enqueue agent. Converts its per-beat write/update strobes into registered write ports for the packet-data and metadata memories, and owns both circular write pointers. When a packet completes, it emits a descriptor to the PIFO stage. It also tracks free buffer space and per-port queued-packet counts, and drives the buffer almost-full bit array back to the enqueue agent.

## Interface
- DATA_WIDTH, 256, packet beat data width
- KEEP_WIDTH, 32, byte-keep width
- SUME_WIDTH, 128, SUME metadata width
- OUTPUT_PORT_COUNT, 5, output ports
- PKT_ADDR_WIDTH, 12, packet memory address width (depth 4096 beats)
- META_ADDR_WIDTH, 11, metadata memory address width (matches PIFO meta_addr field)
- MAX_PKT_BEATS, 64, headroom reserved for one maximum packet
- PORT_PKT_THRESH, 200, per-port queued-packet almost-full threshold
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- s_axis_pkt_info  in  DATA_WIDTH+KEEP_WIDTH+1  {data, keep, last}
- s_axis_sume_meta  in  SUME_WIDTH  metadata of current packet
- s_axis_output_port_bit_array  in  OUTPUT_PORT_COUNT  destination ports
- s_axis_ctl_pkt_wr_en, s_axis_ctl_pkt_addr_update, s_axis_ctl_meta_wr_en, s_axis_ctl_meta_addr_update  in  1 each  strobes from enqueue agent
- s_axis_release_valid  in  1  dequeue side frees one packet, in allocation order
- s_axis_release_beats  in  PKT_ADDR_WIDTH+1  beats freed
- s_axis_port_deq  in  OUTPUT_PORT_COUNT  one bit per port dequeued this cycle
- m_axis_pkt_mem_we / _addr / _din  out  1 / PKT_ADDR_WIDTH / DATA_WIDTH+KEEP_WIDTH+1  packet memory write port
- m_axis_meta_mem_we / _addr / _din  out  1 / META_ADDR_WIDTH / SUME_WIDTH  metadata memory write port
- m_axis_desc_valid  out  1  one-cycle descriptor strobe
- m_axis_desc_meta_addr, m_axis_desc_pkt_addr, m_axis_desc_len, m_axis_desc_ports, m_axis_desc_err  out  META_ADDR_WIDTH, PKT_ADDR_WIDTH, PKT_ADDR_WIDTH+1, OUTPUT_PORT_COUNT, 1
- m_axis_buffer_almost_full_bit_array  out  OUTPUT_PORT_COUNT  to enqueue agent
- m_axis_err_flags  out  3  sticky {release_underflow, overflow, protocol}

## Operation
- FSM: IDLE, BODY.
- IDLE, meta_wr_en & pkt_wr_en: latch meta_addr = meta pointer, start = pkt pointer, ports, len = 1; write metadata and first beat. If last=1, emit the descriptor and stay in IDLE; otherwise go to BODY.
- IDLE, pkt_wr_en without meta_wr_en: beat dropped; set protocol flag.
- BODY, pkt_wr_en: write beat, len += 1. On last=1, emit the descriptor and return to IDLE.
- BODY, meta_wr_en: ignored; set protocol flag.
- Pointer advance: pkt_addr_update advances the packet pointer modulo 2^PKT_ADDR_WIDTH; meta_addr_update does the same for the metadata pointer modulo 2^META_ADDR_WIDTH.
- free_beats (PKT_ADDR_WIDTH+1 bits), reset value 2^PKT_ADDR_WIDTH.
  - Each cycle: free_beats += release_beats (when release_valid) − written beat.
  - Simultaneous release and write both apply in the same cycle.
  - A release that would exceed depth saturates at depth and sets the release_underflow flag.
- Overflow: pkt_wr_en with free_beats==0 suppresses mem_we and holds the pointer; set overflow flag; the descriptor for that packet carries desc_err=1.
- Per-port counts (11 bits each):
  - +1 on descriptor emit with desc_err=0 for each set port bit.
  - −1 on port_deq; saturate at 0.
  - Simultaneous increment and decrement net to no change.
- almost_full[p] = (count[p] >= PORT_PKT_THRESH) | (free_beats < MAX_PKT_BEATS).
- Reset mid-packet: FSM returns to IDLE; pointers, counts, flags and outputs clear; free_beats returns to depth. No descriptor is emitted for the partial packet.

## Timing
- Memory write ports are registered: mem_we, addr and din appear 1 cycle after the strobe.
- Descriptor strobe appears 1 cycle after the last-beat strobe, coincident with the last mem write.
- almost_full is registered: it reflects state 1 cycle after the count/free change. MAX_PKT_BEATS covers this lag and the agent's per-packet decision.
- Reset values: every output 0, except both memory addresses 0 and almost_full 0.
- Back-to-back packets: a last beat followed by the next packet's first beat on the next cycle is accepted with no bubble.

## Configuration
- ENQ_BUF_STATS_EN defined: adds outputs m_axis_stat_pkts (32 bits, descriptors with err=0) and m_axis_stat_drops (32 bits, err descriptors plus protocol drops). Both wrap and clear on rst.
- ENQ_BUF_STATS_EN undefined: these ports and counters are absent.

## Structure
- Shared package holds:
  - FSM state encoding
  - descriptor field widths and offsets
  - error-flag bit indices
  - PKT_INFO_WIDTH = DATA_WIDTH+KEEP_WIDTH+1
- One sub-module, enq_port_counter: a single saturating up/down counter with threshold compare, instantiated OUTPUT_PORT_COUNT times.

## Test plan
- 3-beat packet to port 2 from reset → pkt_addr 0,1,2; meta_addr 0; desc_valid with pkt_addr=0, len=3, ports=5'b00100, err=0; count[2]=1.
- Single-beat packet (last=1 with meta_wr_en) → desc in the following cycle, len=1, FSM stays IDLE; next packet starts at pkt_addr 1.
- Write 4096 beats with no release → beat 4097 suppressed, overflow flag set, desc_err=1. almost_full asserts all bits once free_beats < 64.
- Pointer at 4094 with a 4-beat packet → addresses 4094, 4095, 0, 1; desc_pkt_addr=4094.
- Same-cycle release_beats=10 and a beat write with free_beats=100 → free_beats=109. port_deq[0] with count[0]=200 → almost_full[0] clears.
- rst asserted in BODY after 2 beats → all outputs 0, no descriptor, free_beats=4096; the next packet starts at addr 0.
